// File: rtl/fetch_seq.sv
// Fetch sequencer: walks the fetch PC in 8-byte blocks, keeps one block
// request outstanding at a time, and holds each returned block toward the
// instruction aligner until the aligner and backend take it. A redirect
// flushes the aligner and drops any response that belongs to the old path.
module fetch_seq #(
  parameter int                     VADDR_WIDTH = 32,
  parameter logic [VADDR_WIDTH-1:0] RESET_PC    = VADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [VADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                   i_fetch_ready,
  input  logic                   i_fetch_rsp_valid,
  input  logic [63:0]            i_fetch_rsp_data,
  input  logic                   i_align_stall,
  input  logic                   i_backend_stall,
  output logic                   o_fetch_req,
  output logic [VADDR_WIDTH-1:0] o_fetch_pc,
  output logic                   o_align_valid,
  output logic [VADDR_WIDTH-1:0] o_align_pc,
  output logic [63:0]            o_align_data,
  output logic [3:0]             o_align_hw_valid,
  output logic                   o_align_stall,
  output logic                   o_align_flush
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [VADDR_WIDTH-1:0] pc;
  logic [1:0]             off;
  logic                   fetch_fire;
  logic                   handoff;
  logic [VADDR_WIDTH-1:0] block_pc;

  // The block address is the fetch PC with its byte-in-block bits cleared.
  assign block_pc      = {pc[VADDR_WIDTH-1:3], 3'b000};
  assign o_fetch_pc    = block_pc;
  assign o_fetch_req   = (state == S_FETCH) && !i_redirect;
  assign fetch_fire    = o_fetch_req && i_fetch_ready;
  assign o_align_valid = (state == S_HOLD);
  assign handoff       = (state == S_HOLD) && !i_align_stall && !i_backend_stall;
  assign o_align_stall = i_backend_stall;

  // State register.
  // NOTE: clocked state is written with <= so every flop samples the values
  // from before the edge; blocking = here would create ordering-dependent races.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a redirect overrides the normal flow in every state.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (fetch_fire)        state_nxt = S_WAIT;
      S_WAIT:  if (i_fetch_rsp_valid) state_nxt = S_HOLD;
      S_HOLD:  if (handoff)           state_nxt = S_FETCH;
      S_DRAIN: if (i_fetch_rsp_valid) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
    if (i_redirect) begin
      case (state)
        // A response in the redirect cycle is the stale one; nothing is left
        // outstanding, so fetching can restart immediately.
        S_WAIT:  state_nxt = i_fetch_rsp_valid ? S_FETCH : S_DRAIN;
        S_DRAIN: state_nxt = S_DRAIN;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  // Fetch PC, block offset, held aligner block and the flush pulse.
  // NOTE: the held block and its PC are reset too, so the aligner never sees
  // X on its inputs even though o_align_valid qualifies them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc               <= RESET_PC;
      off              <= 2'd0;
      o_align_data     <= 64'd0;
      o_align_hw_valid <= 4'd0;
      o_align_pc       <= '0;
      o_align_flush    <= 1'b0;
    end else begin
      o_align_flush <= i_redirect;
      if (i_redirect) begin
        // Halfword-aligned target: bit 0 of the redirect address is dropped.
        pc <= i_redirect_pc & ~VADDR_WIDTH'(1);
      end else begin
        if (fetch_fire) off <= pc[2:1];
        if ((state == S_WAIT) && i_fetch_rsp_valid) begin
          o_align_data     <= i_fetch_rsp_data;
          o_align_hw_valid <= 4'b1111 << off;
          o_align_pc       <= pc;
        end
        if (handoff) begin
          pc  <= block_pc + VADDR_WIDTH'(8);
          off <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: a table of block fetches (with optional
// redirects) checked through a scoreboard, plus hand-written sequences for
// stalls, drain, coincident redirect, PC wrap and asynchronous reset.
module tb_fetch_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_fetch_ready;
  logic        i_fetch_rsp_valid;
  logic [63:0] i_fetch_rsp_data;
  logic        i_align_stall;
  logic        i_backend_stall;
  logic        o_fetch_req;
  logic [31:0] o_fetch_pc;
  logic        o_align_valid;
  logic [31:0] o_align_pc;
  logic [63:0] o_align_data;
  logic [3:0]  o_align_hw_valid;
  logic        o_align_stall;
  logic        o_align_flush;

  fetch_seq dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .i_fetch_ready     (i_fetch_ready),
    .i_fetch_rsp_valid (i_fetch_rsp_valid),
    .i_fetch_rsp_data  (i_fetch_rsp_data),
    .i_align_stall     (i_align_stall),
    .i_backend_stall   (i_backend_stall),
    .o_fetch_req       (o_fetch_req),
    .o_fetch_pc        (o_fetch_pc),
    .o_align_valid     (o_align_valid),
    .o_align_pc        (o_align_pc),
    .o_align_data      (o_align_data),
    .o_align_hw_valid  (o_align_hw_valid),
    .o_align_stall     (o_align_stall),
    .o_align_flush     (o_align_flush)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        redir;
    logic [31:0] redir_pc;
    logic [63:0] data;
    int          lat;
    logic [31:0] exp_fetch_pc;
    logic [3:0]  exp_mask;
    logic [31:0] exp_align_pc;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  mask;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Called at a negedge sample point. Waits (bounded) for a request, checks
  // its address, lets it be accepted, returns a block after lat WAIT cycles
  // and checks the held block against the scoreboard. Ends at a negedge in HOLD.
  task automatic issue_and_respond(input logic [63:0] data, input int lat,
                                   input logic [31:0] exp_fetch_pc,
                                   input logic [3:0] exp_mask,
                                   input logic [31:0] exp_align_pc);
    exp_t e;
    exp_t got;
    bit   found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_fetch_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    check("req_seen", {63'd0, found}, 64'd1);
    if (!found) return;
    check("fetch_pc", {32'd0, o_fetch_pc}, {32'd0, exp_fetch_pc});
    step();
    repeat (lat) step();
    i_fetch_rsp_valid = 1'b1;
    i_fetch_rsp_data  = data;
    e.data = data; e.mask = exp_mask; e.pc = exp_align_pc;
    sb.push_back(e);
    @(negedge i_clk);
    check("wait_no_req",   {63'd0, o_fetch_req},   64'd0);
    check("wait_no_valid", {63'd0, o_align_valid}, 64'd0);
    check("wait_no_flush", {63'd0, o_align_flush}, 64'd0);
    step();
    i_fetch_rsp_valid = 1'b0;
    i_fetch_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge i_clk);
    check("align_valid", {63'd0, o_align_valid}, 64'd1);
    check("hold_no_req", {63'd0, o_fetch_req},   64'd0);
    if (o_align_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        got = sb.pop_front();
        check("align_data", o_align_data, got.data);
        check("align_mask", {60'd0, o_align_hw_valid}, {60'd0, got.mask});
        check("align_pc",   {32'd0, o_align_pc}, {32'd0, got.pc});
      end
    end
  endtask

  // Stimulus and checking.
  initial begin
    vecs[0] = '{1'b0, 32'h0,         64'h1122_3344_5566_7788, 1, 32'h8000_0000, 4'b1111, 32'h8000_0000};
    vecs[1] = '{1'b0, 32'h0,         64'hA5A5_0F0F_5A5A_F0F0, 0, 32'h8000_0008, 4'b1111, 32'h8000_0008};
    vecs[2] = '{1'b1, 32'h8000_0106, 64'h0102_0304_0506_0708, 2, 32'h8000_0100, 4'b1000, 32'h8000_0106};
    vecs[3] = '{1'b0, 32'h0,         64'hCAFE_F00D_1234_5678, 0, 32'h8000_0108, 4'b1111, 32'h8000_0108};
    vecs[4] = '{1'b1, 32'h8000_0013, 64'h0F1E_2D3C_4B5A_6978, 1, 32'h8000_0010, 4'b1110, 32'h8000_0012};
    vecs[5] = '{1'b1, 32'h8000_0024, 64'h8877_6655_4433_2211, 0, 32'h8000_0020, 4'b1100, 32'h8000_0024};

    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_fetch_ready = 1'b1;
    i_fetch_rsp_valid = 1'b0; i_fetch_rsp_data = '0;
    i_align_stall = 1'b0; i_backend_stall = 1'b0;

    // Reset state.
    #3;
    check("rst_req",   {63'd0, o_fetch_req},   64'd0);
    check("rst_valid", {63'd0, o_align_valid}, 64'd0);
    check("rst_flush", {63'd0, o_align_flush}, 64'd0);
    check("rst_data",  o_align_data, 64'd0);
    check("rst_pc",    {32'd0, o_fetch_pc}, 64'h8000_0000);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_req", {63'd0, o_fetch_req}, 64'd0);
    @(negedge i_clk);
    check("fetch_req_after_idle", {63'd0, o_fetch_req}, 64'd1);

    // Table of block fetches; redirects are applied while the previous block is held.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].redir) begin
        i_redirect = 1'b1;
        i_redirect_pc = vecs[v].redir_pc;
        step();
        i_redirect = 1'b0;
        @(negedge i_clk);
        check("redir_flush", {63'd0, o_align_flush}, 64'd1);
        check("redir_valid", {63'd0, o_align_valid}, 64'd0);
      end
      issue_and_respond(vecs[v].data, vecs[v].lat, vecs[v].exp_fetch_pc,
                        vecs[v].exp_mask, vecs[v].exp_align_pc);
    end

    // Stalls in HOLD: align stall 1 cycle, backend stall 2 cycles.
    i_align_stall = 1'b1;
    step();
    i_align_stall = 1'b0;
    i_backend_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      check("stall_valid", {63'd0, o_align_valid}, 64'd1);
      check("stall_data",  o_align_data, vecs[5].data);
      check("stall_pc",    {32'd0, o_align_pc}, {32'd0, vecs[5].exp_align_pc});
      check("stall_mask",  {60'd0, o_align_hw_valid}, {60'd0, vecs[5].exp_mask});
      check("stall_req",   {63'd0, o_fetch_req}, 64'd0);
      check("stall_pass",  {63'd0, o_align_stall}, {63'd0, i_backend_stall});
      step();
      if (c == 1) i_backend_stall = 1'b0;
    end
    @(negedge i_clk);
    check("post_stall_req", {63'd0, o_fetch_req}, 64'd1);
    check("post_stall_pc",  {32'd0, o_fetch_pc}, 64'h8000_0028);
    check("post_stall_valid", {63'd0, o_align_valid}, 64'd0);

    // Redirect in WAIT, response 3 cycles later is drained.
    step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h8000_0200;
    @(negedge i_clk);
    check("wait_req_off", {63'd0, o_fetch_req}, 64'd0);
    step();
    i_redirect = 1'b0;
    @(negedge i_clk);
    check("drain_flush",   {63'd0, o_align_flush}, 64'd1);
    check("drain_valid",   {63'd0, o_align_valid}, 64'd0);
    check("drain_req",     {63'd0, o_fetch_req},   64'd0);
    step();
    @(negedge i_clk);
    check("drain_flush_once", {63'd0, o_align_flush}, 64'd0);
    check("drain_req2",       {63'd0, o_fetch_req},   64'd0);
    step();
    i_fetch_rsp_valid = 1'b1;
    i_fetch_rsp_data  = 64'h5555_5555_5555_5555;
    @(negedge i_clk);
    check("drain_valid2", {63'd0, o_align_valid}, 64'd0);
    step();
    i_fetch_rsp_valid = 1'b0;
    @(negedge i_clk);
    check("drain_dropped", {63'd0, o_align_valid}, 64'd0);
    check("drain_req_new", {63'd0, o_fetch_req},   64'd1);
    check("drain_pc_new",  {32'd0, o_fetch_pc},    64'h8000_0200);

    // Redirect coincident with the response in WAIT: no DRAIN.
    step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h8000_0300;
    i_fetch_rsp_valid = 1'b1;
    i_fetch_rsp_data  = 64'h6666_6666_6666_6666;
    step();
    i_redirect = 1'b0;
    i_fetch_rsp_valid = 1'b0;
    @(negedge i_clk);
    check("coinc_valid", {63'd0, o_align_valid}, 64'd0);
    check("coinc_flush", {63'd0, o_align_flush}, 64'd1);
    check("coinc_req",   {63'd0, o_fetch_req},   64'd1);
    check("coinc_pc",    {32'd0, o_fetch_pc},    64'h8000_0300);

    // PC wrap: redirect (from FETCH) to the last block, then hand off.
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    #1;
    check("redir_blocks_req", {63'd0, o_fetch_req}, 64'd0);
    step();
    i_redirect = 1'b0;
    @(negedge i_clk);
    issue_and_respond(64'h0123_4567_89AB_CDEF, 0, 32'hFFFF_FFF8, 4'b1111, 32'hFFFF_FFF8);
    @(negedge i_clk);
    check("wrap_req", {63'd0, o_fetch_req}, 64'd1);
    check("wrap_pc",  {32'd0, o_fetch_pc},  64'd0);
    issue_and_respond(64'hFEDC_BA98_7654_3210, 0, 32'h0, 4'b1111, 32'h0);

    // Asynchronous reset in the middle of a HOLD cycle.
    i_align_stall = 1'b1;
    @(posedge i_clk);
    #3;
    check("pre_rst_valid", {63'd0, o_align_valid}, 64'd1);
    i_rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, o_align_valid}, 64'd0);
    check("arst_req",   {63'd0, o_fetch_req},   64'd0);
    check("arst_flush", {63'd0, o_align_flush}, 64'd0);
    check("arst_mask",  {60'd0, o_align_hw_valid}, 64'd0);
    check("arst_pc",    {32'd0, o_fetch_pc},    64'h8000_0000);
    step();
    i_rst = 1'b0;
    i_align_stall = 1'b0;
    i_fetch_ready = 1'b0;
    i_fetch_rsp_valid = 1'b1;
    i_fetch_rsp_data = 64'h7777_7777_7777_7777;
    @(negedge i_clk);
    check("rel_idle_req", {63'd0, o_fetch_req}, 64'd0);
    step();
    @(negedge i_clk);
    check("rel_fetch_req",   {63'd0, o_fetch_req},   64'd1);
    check("rel_fetch_pc",    {32'd0, o_fetch_pc},    64'h8000_0000);
    check("rel_stale_valid", {63'd0, o_align_valid}, 64'd0);
    step();
    @(negedge i_clk);
    check("rel_stale_valid2", {63'd0, o_align_valid}, 64'd0);
    check("rel_fetch_req2",   {63'd0, o_fetch_req},   64'd1);
    i_fetch_rsp_valid = 1'b0;
    i_fetch_ready = 1'b1;
    issue_and_respond(64'h1357_9BDF_2468_ACE0, 1, 32'h8000_0000, 4'b1111, 32'h8000_0000);

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: a hung run still ends with a failure reported.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
